// File: rtl/ifetch_if.sv
// -----------------------------------------------------------------------------
// ifetch_if
// Groups every handshake and bus signal of the instruction fetch unit:
//   PC side     : pc_addr (PC -> fetch), flush (jump taken; also the PC's
//                 jp_en), stall (fetch -> PC, holds the PC)
//   memory side : mem_req/mem_addr (fetch -> memory), mem_ack/mem_rdata
//                 (memory -> fetch), variable latency
//   decode side : inst_valid/inst/inst_addr/inst_err (fetch -> decode),
//                 inst_ready (decode -> fetch)
// Modports:
//   master : the fetch unit's view
//   slave  : the environment's view (PC, memory and decode together)
// -----------------------------------------------------------------------------
interface ifetch_if;
    logic [31:0] pc_addr;
    logic        flush;
    logic        stall;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_err;

    modport master (
        input  pc_addr, flush, mem_ack, mem_rdata, inst_ready,
        output stall, mem_req, mem_addr, inst_valid, inst, inst_addr, inst_err
    );

    modport slave (
        output pc_addr, flush, mem_ack, mem_rdata, inst_ready,
        input  stall, mem_req, mem_addr, inst_valid, inst, inst_addr, inst_err
    );
endinterface : ifetch_if

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction fetch unit. Takes the PC address stream, performs one memory
// read per instruction over a req/ack bus of variable latency, and presents
// the result in a single-entry output register with a valid/ready handshake.
// Misaligned addresses and bus timeouts deliver NOP with inst_err set.
//
// Parameters:
//   NOP      : instruction word presented on errors and after reset
//   MAX_WAIT : WAIT cycles without mem_ack before a fetch times out (>= 1)
//
// Ports:
//   i_clk    : clock, all registers update on the rising edge
//   i_rst    : synchronous, active-high reset
//   io_fetch : ifetch_if.master -- PC, memory bus and decode handshakes
//              (stall is combinational, all other outputs are registered)
// -----------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] NOP      = 32'h00000013,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic     i_clk,
    input  logic     i_rst,
    ifetch_if.master io_fetch
);

    localparam int unsigned           CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAX_WAIT - 1);

    // IDLE : no bus activity, may capture a new PC address
    // WAIT : read outstanding, the response will be delivered
    // DRAIN: read outstanding after a flush, the response will be dropped
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic             r_inst_valid;
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_addr;
    logic             r_inst_err;

    state_t           w_state_nxt;
    logic             w_slot_free;
    logic             w_capture;
    logic             w_aligned;
    logic             w_timeout;
    logic             w_fill;
    logic [31:0]      w_fill_inst;
    logic [31:0]      w_fill_addr;
    logic             w_fill_err;
    logic             w_load_addr;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    // The slot can take a new instruction when it is empty or being consumed.
    assign w_slot_free = !r_inst_valid || io_fetch.inst_ready;

    // No capture during a flush: pc_addr is the pre-jump address and stale.
    assign w_capture   = (r_state == S_IDLE) && !io_fetch.flush && w_slot_free;
    assign w_aligned   = (io_fetch.pc_addr[1:0] == 2'b00);

    // This WAIT cycle is the last one allowed without an acknowledge.
    assign w_timeout   = (r_state == S_WAIT) && !io_fetch.mem_ack && (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_fill      = 1'b0;
        w_fill_inst = NOP;
        w_fill_addr = r_mem_addr;
        w_fill_err  = 1'b0;
        w_load_addr = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    if (w_aligned) begin
                        w_load_addr = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        // Misaligned: answer immediately without touching the bus.
                        w_fill      = 1'b1;
                        w_fill_addr = io_fetch.pc_addr;
                        w_fill_err  = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (io_fetch.mem_ack) begin
                    // A flush in the same cycle drops the data but still ends the read.
                    w_state_nxt = S_IDLE;
                    w_fill      = !io_fetch.flush;
                    w_fill_inst = io_fetch.mem_rdata;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_timeout) begin
                        // Give up on the bus; a later stray ack lands in IDLE and is ignored.
                        w_state_nxt = S_IDLE;
                        w_fill      = !io_fetch.flush;
                        w_fill_err  = 1'b1;
                    end else if (io_fetch.flush) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // No timeout here: the bus must finish before a new request is issued.
                if (io_fetch.mem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= NOP;
            r_inst_addr  <= '0;
            r_inst_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Request stays high for the whole WAIT/DRAIN residency.
            r_mem_req <= (w_state_nxt != S_IDLE);

            if (w_load_addr) begin
                r_mem_addr <= io_fetch.pc_addr;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A fill never coincides with a flush, so the two branches are exclusive.
            if (w_fill) begin
                r_inst_valid <= 1'b1;
                r_inst       <= w_fill_inst;
                r_inst_addr  <= w_fill_addr;
                r_inst_err   <= w_fill_err;
            end else if (io_fetch.flush || (r_inst_valid && io_fetch.inst_ready)) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // stall is forced low on flush so the PC takes the jump.
    assign io_fetch.stall      = i_rst || !(w_capture || io_fetch.flush);
    assign io_fetch.mem_req    = r_mem_req;
    assign io_fetch.mem_addr   = r_mem_addr;
    assign io_fetch.inst_valid = r_inst_valid;
    assign io_fetch.inst       = r_inst;
    assign io_fetch.inst_addr  = r_inst_addr;
    assign io_fetch.inst_err   = r_inst_err;

endmodule : ifetch

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch
// Randomized environment around ifetch: a PC that follows stall/flush, a
// memory with random acknowledge latency (including stray acks and long
// silences that force timeouts), and a decode stage with random ready.
// A transaction-level reference model predicts bus occupancy, the slot
// contents and the stall output; expected instructions are queued when the
// model predicts a fill and compared by a monitor whenever the DUT shows
// inst_valid.
// -----------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam int          MAX_WAIT = 4;
    localparam int          N_CYCLES = 3000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch #(
        .NOP      (NOP),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_fetch (bus.master)
    );

    // Scoreboard and counters
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: 0 = bus free, 1 = fetch in flight, 2 = flushed read in flight
    int          m_busy     = 0;
    int          m_elapsed  = 0;
    logic [31:0] m_req_addr = '0;
    bit          m_slot     = 1'b0;
    bit          m_rst_seen = 1'b0;
    bit          mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: advances once per rising edge from the inputs seen there
    // -------------------------------------------------------------------------
    initial begin
        bit   fill;
        bit   free;
        exp_t e;
        forever begin
            @(posedge clk);
            mon_en     = 1'b1;
            m_rst_seen = rst;
            if (rst) begin
                m_busy     = 0;
                m_elapsed  = 0;
                m_req_addr = '0;
                m_slot     = 1'b0;
                exp_q.delete();
            end else begin
                fill   = 1'b0;
                free   = !m_slot || bus.inst_ready;
                e.inst = NOP;
                e.addr = m_req_addr;
                e.err  = 1'b0;
                case (m_busy)
                    0: begin
                        if (!bus.flush && free) begin
                            if (bus.pc_addr[1:0] == 2'b00) begin
                                m_busy     = 1;
                                m_elapsed  = 0;
                                m_req_addr = bus.pc_addr;
                            end else begin
                                fill   = 1'b1;
                                e.addr = bus.pc_addr;
                                e.err  = 1'b1;
                            end
                        end
                    end
                    1: begin
                        if (bus.mem_ack) begin
                            m_busy = 0;
                            fill   = !bus.flush;
                            e.inst = bus.mem_rdata;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == MAX_WAIT) begin
                                m_busy = 0;
                                fill   = !bus.flush;
                                e.err  = 1'b1;
                            end else if (bus.flush) begin
                                m_busy = 2;
                            end
                        end
                    end
                    default: begin
                        if (bus.mem_ack) m_busy = 0;
                    end
                endcase

                if (bus.flush) begin
                    m_slot = 1'b0;
                    exp_q.delete();
                end else begin
                    if (m_slot && bus.inst_ready) begin
                        m_slot = 1'b0;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                    if (fill) begin
                        m_slot = 1'b1;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: compares DUT outputs on the falling edge
    // -------------------------------------------------------------------------
    initial begin
        bit exp_stall;
        bit cap;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cap       = (m_busy == 0) && !bus.flush && (!m_slot || bus.inst_ready);
                exp_stall = rst || !(cap || bus.flush);
                check("stall", 32'(bus.stall), 32'(exp_stall));
                if (m_rst_seen) begin
                    check("rst_mem_req",    32'(bus.mem_req),    32'd0);
                    check("rst_mem_addr",   bus.mem_addr,        32'd0);
                    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
                    check("rst_inst",       bus.inst,            NOP);
                    check("rst_inst_addr",  bus.inst_addr,       32'd0);
                    check("rst_inst_err",   32'(bus.inst_err),   32'd0);
                end else begin
                    check("mem_req", 32'(bus.mem_req), 32'(m_busy != 0));
                    if (m_busy != 0) check("mem_addr", bus.mem_addr, m_req_addr);
                    check("inst_valid", 32'(bus.inst_valid), 32'(m_slot));
                    if (bus.inst_valid && exp_q.size() > 0) begin
                        check("inst",      bus.inst,            exp_q[0].inst);
                        check("inst_addr", bus.inst_addr,       exp_q[0].addr);
                        check("inst_err",  32'(bus.inst_err),   32'(exp_q[0].err));
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus: PC, memory and decode environment
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] tmp;
        bit          s;
        int          mode;

        pc             = '0;
        tgt            = '0;
        bus.pc_addr    = '0;
        bus.flush      = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        bus.inst_ready = 1'b0;

        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge clk);
            s = bus.stall;
            @(posedge clk);
            #1;
            // PC reaction to the edge that just passed
            if (rst)            pc = '0;
            else if (bus.flush) pc = tgt;
            else if (!s)        pc = pc + 32'd4;

            rst  = (c < 3) || (c == 1500) || (c == 1501);
            mode = (c < 60) ? 0 : (c < 1200) ? 1 : (c < 2000) ? 2 : 1;

            bus.pc_addr   = pc;
            bus.mem_rdata = $urandom;

            tmp = $urandom;
            if ($urandom_range(0, 5) == 0) tgt = {20'h0, tmp[11:0]} | 32'h1;
            else                           tgt = {20'h0, tmp[11:2], 2'b00};

            case (mode)
                0: begin
                    bus.flush      = 1'b0;
                    bus.inst_ready = 1'b1;
                    bus.mem_ack    = bus.mem_req;
                end
                1: begin
                    bus.flush      = ($urandom_range(0, 99) < 6);
                    bus.inst_ready = ($urandom_range(0, 99) < 75);
                    bus.mem_ack    = ($urandom_range(0, 99) < 45);
                end
                default: begin
                    bus.flush      = ($urandom_range(0, 99) < 5);
                    bus.inst_ready = ($urandom_range(0, 99) < 50);
                    bus.mem_ack    = ($urandom_range(0, 99) < 8);
                end
            endcase
        end

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ifetch

// File: doc/ifetch.md
# ifetch

Instruction fetch unit that consumes the program counter's address stream and returns instructions to decode. It captures `pc_addr`, runs one memory read per instruction over a req/ack bus with variable latency, and holds the result in a single-entry output register under a valid/ready handshake. It drives the PC's `stall` and `jp_en` inputs: `stall` holds the PC, and `flush` marks a taken jump that discards fetch work already in progress.

## Interface
- `NOP`, 32'h00000013, instruction word presented on errors and after reset
- `MAX_WAIT`, 255, number of WAIT cycles without `mem_ack` before a fetch times out (≥1)

- `clk` in 1: clock; every register updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `pc_addr` in 32: current PC address
- `flush` in 1: taken jump this cycle; the same signal drives the PC's `jp_en`
- `stall` out 1: holds the PC when high
- `mem_req` out 1: read request, registered
- `mem_addr` out 32: read address, registered
- `mem_ack` in 1: read complete, `mem_rdata` valid
- `mem_rdata` in 32: read data
- `inst_valid` out 1: output register holds an instruction
- `inst_ready` in 1: decode accepts the instruction
- `inst` out 32: instruction word
- `inst_addr` out 32: address of `inst`
- `inst_err` out 1: `inst` is `NOP` because of a misaligned address or a timeout

## Operation
- States:
  - IDLE: `mem_req`=0.
  - WAIT: `mem_req`=1, `mem_addr` held.
  - DRAIN: `mem_req`=1; the response is discarded.
- Output slot is free when `!inst_valid || inst_ready`.
- Consume: when `inst_valid && inst_ready`, `inst_valid` clears unless a fill happens in the same cycle.
- Capture happens in IDLE when `!flush` and the slot is free:
  - Aligned `pc_addr` (`pc_addr[1:0]`==0): latch `mem_addr<=pc_addr`, clear the timeout counter, go to WAIT.
  - Misaligned `pc_addr`: no bus access. Fill `inst=NOP`, `inst_addr=pc_addr`, `inst_err=1`, `inst_valid=1`. Stay in IDLE.
- `stall` = !(capture || flush). `stall` is forced 0 during `flush` so the PC, whose stall has priority, takes the jump. In a flush cycle no capture happens, because `pc_addr` is stale.
- WAIT:
  - `mem_ack`: fill `inst=mem_rdata`, `inst_addr=mem_addr`, `inst_err=0`, `inst_valid=1`, go to IDLE.
  - Otherwise the counter increments. If the counter reaches `MAX_WAIT`, fill `inst=NOP`, `inst_addr=mem_addr`, `inst_err=1`, `inst_valid=1`, go to IDLE. A later stray `mem_ack` is ignored.
  - The counter is $clog2(MAX_WAIT+1) bits wide and never wraps.
- Flush, in any state:
  - `inst_valid<=0`.
  - WAIT with no `mem_ack` → DRAIN.
  - WAIT with `mem_ack` → IDLE, data discarded.
  - WAIT with timeout in the same cycle → IDLE, no error fill.
  - IDLE → stays IDLE.
  - DRAIN → stays DRAIN.
- DRAIN: on `mem_ack`, discard the data, go to IDLE. No timeout applies in DRAIN.
- Because capture requires a free slot, the slot is always empty when a WAIT fill occurs.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `mem_req`=0, `mem_addr`=0
  - `inst_valid`=0, `inst`=`NOP`, `inst_addr`=0, `inst_err`=0
  - `stall`=1 while `rst` is high
- Reset mid-fetch abandons the bus transaction immediately, with no drain.
- Capture edge at cycle T; WAIT during T+1.
- `mem_ack` at T+1 → `inst_valid`=1 at T+2.
- Best-case throughput: one instruction per 2 cycles (T+2 is IDLE and can capture again if the slot is free).
- Timeout: with no ack, the error fill is visible `MAX_WAIT` cycles after the first WAIT cycle.
- Flush at cycle F: `inst_valid`=0 at F+1; PC holds the jump target at F+1. The earliest capture of the target is F+1 from IDLE; from DRAIN it is the cycle after the ack.
- `stall` is combinational from state, `flush`, `inst_valid`, `inst_ready` and `rst`. All other outputs are registered.

## Test plan
- Reset, then `pc_addr`=0, `mem_ack` one cycle after each request, `inst_ready`=1 → instructions at 0, 4, 8 appear every 2 cycles, each with `inst_err`=0 and the matching `mem_rdata`.
- `inst_ready`=0 for 5 cycles while `inst_valid` is 1 → `inst` and `inst_addr` hold, `stall`=1, `mem_req`=0; raising `inst_ready` resumes the sequence with no instruction lost or duplicated.
- `flush` in the second WAIT cycle, `mem_ack` 3 cycles later → state goes to DRAIN, the acked data is discarded, `stall`=0 in the flush cycle, and the next instruction delivered comes from the jump target.
- `flush` and `mem_ack` in the same cycle → no `inst_valid`, IDLE the next cycle, and the target is captured.
- `MAX_WAIT`=4 with `mem_ack` held low → `inst`=32'h00000013, `inst_err`=1, `inst_addr`=request address; a stray ack afterwards produces no fill.
- `pc_addr`=32'h00000102 → no `mem_req`, `inst_err`=1, `inst`=`NOP`, `inst_addr`=32'h00000102 one cycle after capture.
